axi_wr_arbiter: RTL and testbench
=================================

// Module: axi_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one AXI write path (AW, W, B channels) among NREQ requesters.
//  Sits between the requester ports and axi_protocol's awvalid_in/wvalid_in/bready_in side.
//  Holds one grant from AW handshake through the last W beat to the B handshake.
//  Generates WLAST from the granted AWLEN.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  AW    32  address width
//  GW    2   grant index width, must equal clog2(NREQ)
// PORTS
//  axi_aclk     in   1        single clock, all logic posedge
//  rst          in   1        asynchronous, active-high reset
//  req_awvalid  in   NREQ     per-requester AW valid
//  req_awaddr   in   NREQ*AW  flattened; requester i at [i*AW +: AW]
//  req_awlen    in   NREQ*8   flattened burst length (beats-1)
//  req_awsize   in   NREQ*3   flattened burst size
//  req_awburst  in   NREQ*2   flattened burst type
//  req_awready  out  NREQ     AW ready back to requester
//  req_wvalid   in   NREQ     per-requester W valid
//  req_wdata    in   NREQ*64  flattened write data
//  req_wstrb    in   NREQ*8   flattened byte strobes
//  req_wready   out  NREQ     W ready back to requester
//  req_bvalid   out  NREQ     B valid routed to granted requester
//  req_bresp    out  2        B response (meaningful only with req_bvalid)
//  req_bready   in   NREQ     per-requester B ready
//  axi_awaddr/awlen/awsize/awburst  out  AW/8/3/2  muxed AW fields
//  axi_awvalid  out  1        muxed AW valid
//  axi_awready  in   1        downstream AW ready
//  axi_wdata    out  64       muxed write data
//  axi_wstrb    out  8        muxed strobes
//  axi_wlast    out  1        generated last-beat flag
//  axi_wvalid   out  1        muxed W valid
//  axi_wready   in   1        downstream W ready
//  axi_bresp    in   2        downstream response
//  axi_bvalid   in   1        downstream B valid
//  axi_bready   out  1        muxed B ready
//  grant_id     out  GW       current owner (valid when busy)
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr = NREQ-1 (requester 0 wins first), beat_cnt = 0, grant_id = 0.
//    Every output is 0 while in IDLE; all outputs are gated by state, so reset is seen immediately.
//  - FSM IDLE->ADDR->DATA->RESP->IDLE. Registered state, grant_id, beat_cnt.
//    The channel muxes are combinational on grant_id.
//  - IDLE: if any req_awvalid, grant the first set bit searching from rr_ptr+1 upward, modulo NREQ.
//    Register grant_id and go to ADDR. Grant-to-awvalid latency is 1 cycle.
//  - ADDR: axi_aw* = requester[grant_id] fields. axi_awvalid = req_awvalid[g].
//    req_awready[g] = axi_awready; all other readies are 0.
//    On axi_awvalid & axi_awready: beat_cnt <= awlen[g], go to DATA.
//  - DATA: axi_wvalid = req_wvalid[g], req_wready[g] = axi_wready, axi_wlast = (beat_cnt == 0).
//    Each W handshake decrements beat_cnt (8-bit, no wrap: the last beat exits).
//    The handshake with wlast goes to RESP. A 256-beat burst (awlen = 255) is legal.
//  - RESP: req_bvalid[g] = axi_bvalid, req_bresp = axi_bresp, axi_bready = req_bready[g].
//    On the B handshake: rr_ptr <= grant_id, go to IDLE.
//    A new grant needs one IDLE cycle, so there is a min 1 idle cycle between bursts.
//  - Non-granted requesters see awready/wready/bvalid = 0. Their valids may stay high and wait.
//  - W data offered before AW (by any requester) is stalled; wready stays 0 until DATA.
//  - axi_bvalid outside RESP is ignored, and axi_bready stays 0.
//  - A requester dropping awvalid in ADDR leaves the grant held. The arbiter does not revoke.
//  - Reset mid-burst: immediate return to IDLE. Any partial burst is abandoned and no WLAST is forced.
// TESTING
//  - Single req0, awlen=3, all readies=1 -> awvalid 1 cycle after req;
//    4 W beats with wlast only on 4th; B routed to req0; busy low after B.
//  - req0..req3 awvalid all held, awlen=0 each -> grants in order 0,1,2,3,0;
//    grant_id changes only after each B handshake.
//  - req2 granted, axi_wready toggles 1/0 with awlen=2 -> exactly 3 beats;
//    wlast high only while beat_cnt=0; req2 wdata passes through unchanged.
//  - req1 holds wvalid=1 while req0 owns the bus -> req_wready[1]=0 throughout;
//    req1 data is accepted only after its own AW handshake.
//  - awlen=255 burst -> 256 W handshakes, wlast on the 256th only, no counter wrap.
//  - rst asserted during DATA beat 2 of 4 -> all outputs 0 the same cycle;
//    after release, requester 0 wins first.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// axi_wr_arbiter : round-robin owner of one shared AXI write path (AW/W/B)
// Revision: 1.0
// ============================================================================
module axi_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int GW   = 2
) (
  input  logic                axi_aclk,
  input  logic                rst,

  input  logic [NREQ-1:0]     req_awvalid,
  input  logic [NREQ*AW-1:0]  req_awaddr,
  input  logic [NREQ*8-1:0]   req_awlen,
  input  logic [NREQ*3-1:0]   req_awsize,
  input  logic [NREQ*2-1:0]   req_awburst,
  output logic [NREQ-1:0]     req_awready,
  input  logic [NREQ-1:0]     req_wvalid,
  input  logic [NREQ*64-1:0]  req_wdata,
  input  logic [NREQ*8-1:0]   req_wstrb,
  output logic [NREQ-1:0]     req_wready,
  output logic [NREQ-1:0]     req_bvalid,
  output logic [1:0]          req_bresp,
  input  logic [NREQ-1:0]     req_bready,

  output logic [AW-1:0]       axi_awaddr,
  output logic [7:0]          axi_awlen,
  output logic [2:0]          axi_awsize,
  output logic [1:0]          axi_awburst,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [63:0]         axi_wdata,
  output logic [7:0]          axi_wstrb,
  output logic                axi_wlast,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,

  output logic [GW-1:0]       grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] grant_nxt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] search_idx;
  logic [7:0]    beat_cnt;
  logic          found;
  logic          any_req;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          last_beat;

  logic [AW-1:0] awaddr_a  [NREQ];
  logic [7:0]    awlen_a   [NREQ];
  logic [2:0]    awsize_a  [NREQ];
  logic [1:0]    awburst_a [NREQ];
  logic [63:0]   wdata_a   [NREQ];
  logic [7:0]    wstrb_a   [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign awaddr_a[i]  = req_awaddr[i*AW +: AW];
    assign awlen_a[i]   = req_awlen[i*8 +: 8];
    assign awsize_a[i]  = req_awsize[i*3 +: 3];
    assign awburst_a[i] = req_awburst[i*2 +: 2];
    assign wdata_a[i]   = req_wdata[i*64 +: 64];
    assign wstrb_a[i]   = req_wstrb[i*8 +: 8];
  end

  assign any_req   = |req_awvalid;
  assign last_beat = (beat_cnt == 8'd0);
  assign aw_hs     = axi_awvalid & axi_awready;
  assign w_hs      = axi_wvalid & axi_wready;
  assign b_hs      = axi_bvalid & axi_bready;

  // First requesting index after the last owner, wrapping modulo NREQ.
  always_comb begin
    grant_nxt  = grant_q;
    search_idx = '0;
    found      = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      search_idx = GW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_awvalid[search_idx]) begin
        found     = 1'b1;
        grant_nxt = search_idx;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req)              state_nxt = ST_ADDR;
      ST_ADDR: if (aw_hs)                state_nxt = ST_DATA;
      ST_DATA: if (w_hs && last_beat)    state_nxt = ST_RESP;
      ST_RESP: if (b_hs)                 state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // beat_cnt holds beats remaining after the current one; the last beat exits DATA
  // instead of decrementing, so a 256-beat burst never wraps.
  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      grant_q  <= '0;
      rr_ptr   <= GW'(NREQ - 1);
      beat_cnt <= 8'd0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        grant_q <= grant_nxt;
      end
      if (aw_hs) begin
        beat_cnt <= awlen_a[grant_q];
      end else if (w_hs && !last_beat) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
      if (b_hs) begin
        rr_ptr <= grant_q;
      end
    end
  end

  // Every output is gated by state so IDLE (and reset) drive all zeros.
  always_comb begin
    req_awready = '0;
    req_wready  = '0;
    req_bvalid  = '0;
    req_bresp   = 2'b00;
    axi_awaddr  = '0;
    axi_awlen   = 8'd0;
    axi_awsize  = 3'd0;
    axi_awburst = 2'd0;
    axi_awvalid = 1'b0;
    axi_wdata   = 64'd0;
    axi_wstrb   = 8'd0;
    axi_wlast   = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    busy        = (state != ST_IDLE);
    grant_id    = '0;
    case (state)
      ST_ADDR: begin
        grant_id             = grant_q;
        axi_awaddr           = awaddr_a[grant_q];
        axi_awlen            = awlen_a[grant_q];
        axi_awsize           = awsize_a[grant_q];
        axi_awburst          = awburst_a[grant_q];
        axi_awvalid          = req_awvalid[grant_q];
        req_awready[grant_q] = axi_awready;
      end
      ST_DATA: begin
        grant_id            = grant_q;
        axi_wdata           = wdata_a[grant_q];
        axi_wstrb           = wstrb_a[grant_q];
        axi_wvalid          = req_wvalid[grant_q];
        axi_wlast           = last_beat;
        req_wready[grant_q] = axi_wready;
      end
      ST_RESP: begin
        grant_id            = grant_q;
        req_bvalid[grant_q] = axi_bvalid;
        req_bresp           = axi_bresp;
        axi_bready          = req_bready[grant_q];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axi_wr_arbiter : directed self-checking bench for axi_wr_arbiter
// Revision: 1.0
// ============================================================================
module tb_axi_wr_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_awvalid;
  logic [127:0] req_awaddr;
  logic [31:0]  req_awlen;
  logic [11:0]  req_awsize;
  logic [7:0]   req_awburst;
  logic [3:0]   req_awready;
  logic [3:0]   req_wvalid;
  logic [255:0] req_wdata;
  logic [31:0]  req_wstrb;
  logic [3:0]   req_wready;
  logic [3:0]   req_bvalid;
  logic [1:0]   req_bresp;
  logic [3:0]   req_bready;
  logic [31:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [63:0]  axi_wdata;
  logic [7:0]   axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready;
  logic [1:0]   grant_id;
  logic         busy;

  int checks = 0;
  int errors = 0;

  axi_wr_arbiter #(.NREQ(4), .AW(32), .GW(2)) dut (
    .axi_aclk    (clk),
    .rst         (rst),
    .req_awvalid (req_awvalid),
    .req_awaddr  (req_awaddr),
    .req_awlen   (req_awlen),
    .req_awsize  (req_awsize),
    .req_awburst (req_awburst),
    .req_awready (req_awready),
    .req_wvalid  (req_wvalid),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_wready  (req_wready),
    .req_bvalid  (req_bvalid),
    .req_bresp   (req_bresp),
    .req_bready  (req_bready),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_awvalid = '0; req_awaddr = '0; req_awlen = '0; req_awsize = '0;
    req_awburst = '0; req_wvalid = '0; req_wdata = '0; req_wstrb = '0;
    req_bready  = '0; axi_awready = 1'b0; axi_wready = 1'b0;
    axi_bresp   = 2'b00; axi_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_aw(input int i, input logic [31:0] addr, input logic [7:0] len);
    req_awaddr[i*32 +: 32] = addr;
    req_awlen[i*8 +: 8]    = len;
    req_awsize[i*3 +: 3]   = 3'd3;
    req_awburst[i*2 +: 2]  = 2'b01;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    req_awvalid = 4'hF; req_wvalid = 4'hF; req_bready = 4'hF;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
    checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %0b exp 0", axi_awvalid); end
    checks++; if (req_awready !== 4'h0) begin errors++; $display("FAIL reset_awready: got %b exp 0000", req_awready); end
    checks++; if (req_wready !== 4'h0) begin errors++; $display("FAIL reset_wready: got %b exp 0000", req_wready); end
    checks++; if (axi_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %0b exp 0", axi_wvalid); end
    checks++; if (axi_wlast !== 1'b0) begin errors++; $display("FAIL reset_wlast: got %0b exp 0", axi_wlast); end
    checks++; if (axi_bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %0b exp 0", axi_bready); end
    checks++; if (req_bvalid !== 4'h0) begin errors++; $display("FAIL reset_bvalid: got %b exp 0000", req_bvalid); end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single();
    logic [63:0] d;
    do_reset();
    set_aw(0, 32'h1000_0040, 8'd3);
    req_awvalid = 4'b0001; axi_awready = 1'b1; axi_wready = 1'b1;
    #1;
    checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL single_aw_latency: got %0b exp 0", axi_awvalid); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b exp 1", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d exp 0", grant_id); end
    checks++; if (axi_awvalid !== 1'b1) begin errors++; $display("FAIL single_awvalid: got %0b exp 1", axi_awvalid); end
    checks++; if (axi_awaddr !== 32'h1000_0040) begin errors++; $display("FAIL single_awaddr: got %h exp 10000040", axi_awaddr); end
    checks++; if (axi_awlen !== 8'd3) begin errors++; $display("FAIL single_awlen: got %0d exp 3", axi_awlen); end
    checks++; if (axi_awsize !== 3'd3 || axi_awburst !== 2'b01) begin errors++; $display("FAIL single_awsize_burst: got %0d/%0d exp 3/1", axi_awsize, axi_awburst); end
    checks++; if (req_awready !== 4'b0001) begin errors++; $display("FAIL single_awready: got %b exp 0001", req_awready); end
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b0001;
    for (int b = 0; b < 4; b++) begin
      d = 64'hA0A0_0000_0000_0000 + 64'(b);
      req_wdata[63:0] = d;
      req_wstrb[7:0]  = 8'h0F + 8'(b);
      #1;
      checks++; if (axi_wvalid !== 1'b1) begin errors++; $display("FAIL single_wvalid beat %0d: got %0b exp 1", b, axi_wvalid); end
      checks++; if (axi_wdata !== d) begin errors++; $display("FAIL single_wdata beat %0d: got %h exp %h", b, axi_wdata, d); end
      checks++; if (axi_wstrb !== 8'h0F + 8'(b)) begin errors++; $display("FAIL single_wstrb beat %0d: got %h exp %h", b, axi_wstrb, 8'h0F + 8'(b)); end
      checks++; if (axi_wlast !== (b == 3)) begin errors++; $display("FAIL single_wlast beat %0d: got %0b exp %0b", b, axi_wlast, (b == 3)); end
      checks++; if (req_wready !== 4'b0001) begin errors++; $display("FAIL single_wready beat %0d: got %b exp 0001", b, req_wready); end
      tick();
    end
    req_wvalid = 4'b0000;
    axi_bvalid = 1'b1; axi_bresp = 2'b10; req_bready = 4'b0001;
    #1;
    checks++; if (axi_wvalid !== 1'b0) begin errors++; $display("FAIL single_no_extra_beat: got %0b exp 0", axi_wvalid); end
    checks++; if (req_bvalid !== 4'b0001) begin errors++; $display("FAIL single_bvalid: got %b exp 0001", req_bvalid); end
    checks++; if (req_bresp !== 2'b10) begin errors++; $display("FAIL single_bresp: got %b exp 10", req_bresp); end
    checks++; if (axi_bready !== 1'b1) begin errors++; $display("FAIL single_bready: got %0b exp 1", axi_bready); end
    tick();
    axi_bvalid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_b: got %0b exp 0", busy); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    bit          ok;
    do_reset();
    for (int i = 0; i < 4; i++) set_aw(i, 32'h2000_0000 + 32'(i) * 32'h100, 8'd0);
    req_awvalid = 4'hF; req_wvalid = 4'hF; req_bready = 4'hF;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp_g = 2'(n % 4);
      exp_a = 32'h2000_0000 + 32'(exp_g) * 32'h100;
      ok = 1'b0;
      for (int c = 0; c < 8 && !ok; c++) begin
        tick();
        if (busy) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout burst %0d: busy never rose", n); end
      checks++; if (grant_id !== exp_g) begin errors++; $display("FAIL rr_grant burst %0d: got %0d exp %0d", n, grant_id, exp_g); end
      checks++; if (axi_awaddr !== exp_a) begin errors++; $display("FAIL rr_awaddr burst %0d: got %h exp %h", n, axi_awaddr, exp_a); end
      checks++; if (req_awready !== 4'(1 << exp_g)) begin errors++; $display("FAIL rr_awready burst %0d: got %b exp %b", n, req_awready, 4'(1 << exp_g)); end
      ok = 1'b0;
      for (int c = 0; c < 8 && !ok; c++) begin
        tick();
        if (!busy) ok = 1'b1;
        else begin
          checks++; if (grant_id !== exp_g) begin errors++; $display("FAIL rr_grant_held burst %0d: got %0d exp %0d", n, grant_id, exp_g); end
        end
      end
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout burst %0d: busy never fell", n); end
    end
    clear_inputs();
  endtask

  task automatic test_wready_toggle();
    logic [63:0] d;
    int          beats;
    logic        w;
    do_reset();
    set_aw(2, 32'h3000_0000, 8'd2);
    req_awvalid = 4'b0100; axi_awready = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL toggle_grant: got %0d exp 2", grant_id); end
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b0100;
    beats = 0;
    for (int cyc = 0; cyc < 12 && beats < 3; cyc++) begin
      w = (cyc % 2 == 1);
      axi_wready = w;
      d = 64'hC0DE_0000_0000_0000 | 64'(cyc);
      req_wdata[2*64 +: 64] = d;
      #1;
      checks++; if (axi_wdata !== d) begin errors++; $display("FAIL toggle_wdata cyc %0d: got %h exp %h", cyc, axi_wdata, d); end
      checks++; if (axi_wlast !== (beats == 2)) begin errors++; $display("FAIL toggle_wlast cyc %0d: got %0b exp %0b", cyc, axi_wlast, (beats == 2)); end
      checks++; if (req_wready !== (w ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL toggle_wready cyc %0d: got %b", cyc, req_wready); end
      if (w) beats++;
      tick();
    end
    checks++; if (beats != 3) begin errors++; $display("FAIL toggle_beats: got %0d exp 3", beats); end
    axi_wready = 1'b1;
    #1;
    checks++; if (axi_wvalid !== 1'b0 || req_wready !== 4'b0000) begin errors++; $display("FAIL toggle_extra_beat: wvalid %0b wready %b exp 0/0000", axi_wvalid, req_wready); end
    axi_bvalid = 1'b1; axi_bresp = 2'b01; req_bready = 4'b0100;
    #1;
    checks++; if (req_bvalid !== 4'b0100) begin errors++; $display("FAIL toggle_bvalid: got %b exp 0100", req_bvalid); end
    tick();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_busy_end: got %0b exp 0", busy); end
  endtask

  task automatic test_w_stall();
    logic [63:0] d1;
    d1 = 64'h1111_2222_3333_4444;
    do_reset();
    set_aw(0, 32'h4000_0000, 8'd1);
    set_aw(1, 32'h4100_0000, 8'd0);
    req_awvalid = 4'b0001; req_wvalid = 4'b0011;
    req_wdata[63:0] = 64'h0000_0000_DEAD_BEEF; req_wdata[127:64] = d1;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1; req_bready = 4'b0001;
    #1;
    checks++; if (req_wready !== 4'b0000) begin errors++; $display("FAIL stall_idle_wready: got %b exp 0000", req_wready); end
    tick();
    checks++; if (req_wready !== 4'b0000) begin errors++; $display("FAIL stall_addr_wready: got %b exp 0000", req_wready); end
    tick();
    req_awvalid = 4'b0000;
    #1;
    checks++; if (req_wready !== 4'b0001) begin errors++; $display("FAIL stall_data0_wready: got %b exp 0001", req_wready); end
    tick();
    checks++; if (req_wready !== 4'b0001 || axi_wlast !== 1'b1) begin errors++; $display("FAIL stall_data1: wready %b wlast %0b exp 0001/1", req_wready, axi_wlast); end
    tick();
    checks++; if (req_wready !== 4'b0000) begin errors++; $display("FAIL stall_resp_wready: got %b exp 0000", req_wready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_req0_done: busy %0b exp 0", busy); end
    req_awvalid = 4'b0010; req_wvalid = 4'b0010; req_bready = 4'b0010; axi_awready = 1'b0;
    tick();
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL stall_grant1: got %0d exp 1", grant_id); end
    checks++; if (req_wready !== 4'b0000) begin errors++; $display("FAIL stall_pre_aw_wready: got %b exp 0000", req_wready); end
    req_awvalid = 4'b0000;
    #1;
    checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL stall_awvalid_drop: got %0b exp 0", axi_awvalid); end
    tick();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL stall_grant_kept: busy %0b grant %0d exp 1/1", busy, grant_id); end
    req_awvalid = 4'b0010; axi_awready = 1'b1;
    #1;
    checks++; if (req_awready !== 4'b0010) begin errors++; $display("FAIL stall_awready1: got %b exp 0010", req_awready); end
    tick();
    req_awvalid = 4'b0000;
    #1;
    checks++; if (req_wready !== 4'b0010) begin errors++; $display("FAIL stall_wready1: got %b exp 0010", req_wready); end
    checks++; if (axi_wdata !== d1) begin errors++; $display("FAIL stall_wdata1: got %h exp %h", axi_wdata, d1); end
    checks++; if (axi_wlast !== 1'b1) begin errors++; $display("FAIL stall_wlast1: got %0b exp 1", axi_wlast); end
    tick();
    checks++; if (req_bvalid !== 4'b0010) begin errors++; $display("FAIL stall_bvalid1: got %b exp 0010", req_bvalid); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_req1_done: busy %0b exp 0", busy); end
    clear_inputs();
  endtask

  task automatic test_long_burst();
    int  beats;
    int  lasts;
    bit  done;
    do_reset();
    set_aw(3, 32'h5000_0000, 8'd255);
    req_awvalid = 4'b1000; req_wvalid = 4'b1000;
    axi_awready = 1'b1; axi_wready = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd3 || axi_awlen !== 8'd255) begin errors++; $display("FAIL long_addr: grant %0d awlen %0d exp 3/255", grant_id, axi_awlen); end
    tick();
    req_awvalid = 4'b0000;
    beats = 0; lasts = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      req_wdata[3*64 +: 64] = 64'(beats);
      #1;
      if (axi_wlast) begin
        lasts++;
        checks++; if (beats != 255) begin errors++; $display("FAIL long_wlast_pos: wlast at beat %0d exp 255", beats); end
      end
      if (axi_wvalid && axi_wready) begin
        beats++;
        if (axi_wlast) done = 1'b1;
      end
      tick();
    end
    checks++; if (beats != 256) begin errors++; $display("FAIL long_beats: got %0d exp 256", beats); end
    checks++; if (lasts != 1) begin errors++; $display("FAIL long_wlast_count: got %0d exp 1", lasts); end
    checks++; if (axi_wvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL long_resp_state: wvalid %0b busy %0b exp 0/1", axi_wvalid, busy); end
    axi_bvalid = 1'b1; req_bready = 4'b1000;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_aw(0, 32'h6000_0000, 8'd0);
    req_awvalid = 4'b0001; req_wvalid = 4'b0001; req_bready = 4'b0001;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1;
    tick();
    tick();
    req_awvalid = 4'b0000;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_first_done: busy %0b exp 0", busy); end
    set_aw(0, 32'h6000_1000, 8'd3);
    req_awvalid = 4'b0001; axi_bvalid = 1'b0;
    tick();
    tick();
    req_awvalid = 4'b0000;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b exp 0", busy); end
    checks++; if (axi_wvalid !== 1'b0 || axi_wlast !== 1'b0) begin errors++; $display("FAIL midrst_w: wvalid %0b wlast %0b exp 0/0", axi_wvalid, axi_wlast); end
    checks++; if (req_wready !== 4'b0000) begin errors++; $display("FAIL midrst_wready: got %b exp 0000", req_wready); end
    checks++; if (grant_id !== 2'd0 || axi_awvalid !== 1'b0) begin errors++; $display("FAIL midrst_grant_aw: grant %0d awvalid %0b exp 0/0", grant_id, axi_awvalid); end
    tick();
    rst = 1'b0;
    set_aw(1, 32'h6100_0000, 8'd0);
    req_awvalid = 4'b0011; req_wvalid = 4'b0000;
    tick();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL midrst_first_winner: busy %0b grant %0d exp 1/0", busy, grant_id); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_wready_toggle();
    test_w_stall();
    test_long_burst();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
